pipe_ctrl: RTL and testbench
============================

// Module: pipe_ctrl
// PURPOSE
//  Parametrised pipeline-register and hazard-control block for the RV32IC core. It generalises the
//  fixed 4-stage stall chain to STAGES stages and owns per-stage instr/PC/valid registers.
//  It adds valid bits, NOP bubble insertion, and a flush/ack handshake for taken jumps and branches.
//  It also keeps saturating stall, bubble and retire counters. It sits between the ifu (stage 0) and
//  the decode/execute/lsu stages.
// PARAMETERS
//  XLEN      32  data/PC width
//  STAGES    4   pipeline length incl. fetch stage 0 (legal 3..8); registers held for stages 1..STAGES-1
//  BR_STAGE  2   stage in which jumps/branches resolve (legal 1..STAGES-2)
//  CNT_W     32  width of each performance counter
//  NOP       30'h4  instr[31:2] encoding of a bubble (addi x0,x0,0)
// PORTS
//  clk          in   1               clock, all state on rising edge
//  rst_n        in   1               asynchronous active-low reset
//  if_instr     in   30              stage-0 instr[31:2] from ifu
//  if_valid     in   1               stage-0 instr is real (ifu not mid-fetch)
//  if_curr_pc   in   XLEN            stage-0 PC
//  if_inc_pc    in   XLEN            stage-0 next sequential PC
//  stalled      in   STAGES          stalled[k]: stage k cannot complete this cycle
//  flush_req    in   1               jump/branch taken in BR_STAGE; held until flush_ack
//  flush_ack    out  1               flush accepted this edge (combinational)
//  stall        out  STAGES          stall[k] = stalled[k] | stall[k+1]; stall[STAGES-1] = stalled[STAGES-1]
//  instr        out  30*(STAGES-1)   slice k-1 = stage k instr[31:2]
//  curr_pc      out  XLEN*(STAGES-1) per-stage PC, same slicing
//  inc_pc       out  XLEN*(STAGES-1) per-stage next PC, same slicing
//  valid        out  STAGES-1        per-stage valid
//  stall_cnt    out  CNT_W           cycles with stall[0]=1
//  bubble_cnt   out  CNT_W           bubbles injected (stall- or flush-caused)
//  retire_cnt   out  CNT_W           valid instrs leaving stage STAGES-1
// BEHAVIOUR
//  - Reset (async, rst_n=0): all instr=NOP, valid=0, curr_pc/inc_pc=0, counters=0. Outputs settle without clk.
//  - Stall chain is purely combinational; no latency from stalled to stall.
//  - Per edge, for stage k in 1..STAGES-1, in priority order:
//    1. flush_ack & k<=BR_STAGE -> instr=NOP, valid=0.
//    2. stall[k]=1 -> hold all fields.
//    3. stall[k-1]=1 -> bubble: instr=NOP, valid=0; PCs hold.
//    4. otherwise -> load from stage k-1 (stage 0 = if_* inputs, valid=if_valid).
//  - flush_ack = flush_req & !stall[BR_STAGE]. The flushing instr advances to BR_STAGE+1 on the ack
//    edge. Stage BR_STAGE+1 and older are untouched. If stall[BR_STAGE]=1, no ack; flush_req must stay high.
//  - Retire: stage STAGES-1 with valid=1 & !stall[STAGES-1] -> retire_cnt+1.
//  - bubble_cnt: +1 per edge if any stage takes rule 3 with stage k-1 valid.
//    Also +1 per edge for a flush_ack edge, regardless of count of stages killed.
//  - Counters saturate at all-ones and never wrap.
//  - Simultaneous flush and stall on a stage <=BR_STAGE: flush wins; data is killed, not held.
//  - Reset mid-flush or mid-stall: flush_req is forgotten; pipeline restarts empty.
// TESTING
//  1. Reset, stream 8 valid instrs, no stalls -> each appears at stage k k cycles later; retire_cnt=8-(STAGES-1)+... matches count exiting.
//  2. stalled[3]=1 for 3 cycles -> stall=4'b1111 those cycles, all stages hold, stall_cnt=3, bubble_cnt=0.
//  3. stalled[1]=1 for 1 cycle with stages full -> stage 2 gets NOP/valid=0 next edge; bubble_cnt=1.
//  4. flush_req with stall clear -> flush_ack same cycle; stages 1..2 NOP/valid=0; branch instr in stage 3; bubble_cnt+1.
//  5. flush_req while stalled[3]=1 for 2 cycles -> flush_ack=0 until stall drops, then ack and flush as in 4.
//  6. CNT_W=4, 20 stall cycles -> stall_cnt=4'hF held; assert rst_n=0 mid-run -> all counters 0 and valid=0 asynchronously.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Per-stage instr/PC/valid pipeline registers with combinational stall chain,
// bubble insertion, branch flush handshake and saturating performance counters.
module pipe_ctrl #(
    parameter int          XLEN     = 32,
    parameter int          STAGES   = 4,
    parameter int          BR_STAGE = 2,
    parameter int          CNT_W    = 32,
    parameter logic [29:0] NOP      = 30'h4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [29:0]                if_instr,
    input  logic                       if_valid,
    input  logic [XLEN-1:0]            if_curr_pc,
    input  logic [XLEN-1:0]            if_inc_pc,
    input  logic [STAGES-1:0]          stalled,
    input  logic                       flush_req,
    output logic                       flush_ack,
    output logic [STAGES-1:0]          stall,
    output logic [30*(STAGES-1)-1:0]   instr,
    output logic [XLEN*(STAGES-1)-1:0] curr_pc,
    output logic [XLEN*(STAGES-1)-1:0] inc_pc,
    output logic [STAGES-2:0]          valid,
    output logic [CNT_W-1:0]           stall_cnt,
    output logic [CNT_W-1:0]           bubble_cnt,
    output logic [CNT_W-1:0]           retire_cnt
);
    localparam int NS = STAGES - 1;

    logic [NS-1:0][29:0]     instr_q, instr_d, src_instr_s;
    logic [NS-1:0]           valid_q, valid_d, src_valid_s;
    logic [NS-1:0][XLEN-1:0] cpc_q, cpc_d, src_cpc_s;
    logic [NS-1:0][XLEN-1:0] ipc_q, ipc_d, src_ipc_s;
    logic [CNT_W-1:0]        stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]        bubble_cnt_q, bubble_cnt_d;
    logic [CNT_W-1:0]        retire_cnt_q, retire_cnt_d;
    logic [STAGES-1:0]       stall_s;
    logic                    flush_ack_s;
    logic                    bubble_hit_s;
    logic                    retire_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic inc);
        logic [CNT_W-1:0] res;
        if (inc && (cnt != {CNT_W{1'b1}})) begin
            res = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            res = cnt;
        end
        return res;
    endfunction

    // Stage k stalls when it or any younger-to-retire stage above it is stuck.
    always_comb begin
        stall_s = {STAGES{1'b0}};
        for (int k = 0; k < STAGES; k++) begin
            stall_s[k] = |(stalled >> k);
        end
    end

    assign flush_ack_s = flush_req & ~stall_s[BR_STAGE];
    assign retire_s    = valid_q[NS-1] & ~stall_s[STAGES-1];

    // Each stage's source is the stage below it; stage 0 is the fetch unit.
    assign src_instr_s = {instr_q[NS-2:0], if_instr};
    assign src_valid_s = {valid_q[NS-2:0], if_valid};
    assign src_cpc_s   = {cpc_q[NS-2:0], if_curr_pc};
    assign src_ipc_s   = {ipc_q[NS-2:0], if_inc_pc};

    // Next-state per stage: flush, hold, bubble or advance, in that priority.
    always_comb begin
        instr_d      = instr_q;
        valid_d      = valid_q;
        cpc_d        = cpc_q;
        ipc_d        = ipc_q;
        bubble_hit_s = 1'b0;
        for (int j = 0; j < NS; j++) begin
            if (flush_ack_s && ((j + 1) <= BR_STAGE)) begin
                instr_d[j] = NOP;
                valid_d[j] = 1'b0;
            end else if (stall_s[j+1]) begin
                instr_d[j] = instr_q[j];
                valid_d[j] = valid_q[j];
            end else if (stall_s[j]) begin
                instr_d[j] = NOP;
                valid_d[j] = 1'b0;
                if (src_valid_s[j]) begin
                    bubble_hit_s = 1'b1;
                end else begin
                    bubble_hit_s = bubble_hit_s;
                end
            end else begin
                instr_d[j] = src_instr_s[j];
                valid_d[j] = src_valid_s[j];
                cpc_d[j]   = src_cpc_s[j];
                ipc_d[j]   = src_ipc_s[j];
            end
        end
        stall_cnt_d  = sat_inc(stall_cnt_q, stall_s[0]);
        bubble_cnt_d = sat_inc(bubble_cnt_q, bubble_hit_s | flush_ack_s);
        retire_cnt_d = sat_inc(retire_cnt_q, retire_s);
    end

    // Pipeline and counter registers; reset empties the pipe and drops any pending flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q      <= {NS{NOP}};
            valid_q      <= {NS{1'b0}};
            cpc_q        <= {(NS*XLEN){1'b0}};
            ipc_q        <= {(NS*XLEN){1'b0}};
            stall_cnt_q  <= {CNT_W{1'b0}};
            bubble_cnt_q <= {CNT_W{1'b0}};
            retire_cnt_q <= {CNT_W{1'b0}};
        end else begin
            instr_q      <= instr_d;
            valid_q      <= valid_d;
            cpc_q        <= cpc_d;
            ipc_q        <= ipc_d;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign flush_ack  = flush_ack_s;
    assign stall      = stall_s;
    assign instr      = instr_q;
    assign valid      = valid_q;
    assign curr_pc    = cpc_q;
    assign inc_pc     = ipc_q;
    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
    assign retire_cnt = retire_cnt_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed phases plus random traffic checked against a
// stage-record reference model with saturating integer counters.
module tb_pipe_ctrl;
    localparam int          XLEN   = 32;
    localparam int          STAGES = 4;
    localparam int          BR     = 2;
    localparam int          CNT_W  = 4;
    localparam int          CMAX   = 15;
    localparam logic [29:0] NOPI   = 30'h4;

    logic                    clk;
    logic                    rst_n;
    logic [29:0]             if_instr;
    logic                    if_valid;
    logic [XLEN-1:0]         if_curr_pc;
    logic [XLEN-1:0]         if_inc_pc;
    logic [STAGES-1:0]       stalled;
    logic                    flush_req;
    logic                    flush_ack;
    logic [STAGES-1:0]       stall;
    logic [30*(STAGES-1)-1:0]   instr;
    logic [XLEN*(STAGES-1)-1:0] curr_pc;
    logic [XLEN*(STAGES-1)-1:0] inc_pc;
    logic [STAGES-2:0]       valid;
    logic [CNT_W-1:0]        stall_cnt;
    logic [CNT_W-1:0]        bubble_cnt;
    logic [CNT_W-1:0]        retire_cnt;

    pipe_ctrl #(.XLEN(XLEN), .STAGES(STAGES), .BR_STAGE(BR), .CNT_W(CNT_W), .NOP(NOPI)) dut (
        .clk(clk), .rst_n(rst_n), .if_instr(if_instr), .if_valid(if_valid),
        .if_curr_pc(if_curr_pc), .if_inc_pc(if_inc_pc), .stalled(stalled),
        .flush_req(flush_req), .flush_ack(flush_ack), .stall(stall), .instr(instr),
        .curr_pc(curr_pc), .inc_pc(inc_pc), .valid(valid), .stall_cnt(stall_cnt),
        .bubble_cnt(bubble_cnt), .retire_cnt(retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int fails  = 0;
    int total  = 0;

    // Reference model: one record per stage 1..STAGES-1.
    logic [29:0] m_instr [1:STAGES-1];
    bit          m_valid [1:STAGES-1];
    logic [31:0] m_cpc   [1:STAGES-1];
    logic [31:0] m_ipc   [1:STAGES-1];
    bit          m_stall [0:STAGES-1];
    bit          m_ack;
    int          m_sc, m_bc, m_rc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int c);
        return (c < CMAX) ? c + 1 : c;
    endfunction

    task automatic m_reset();
        for (int k = 1; k < STAGES; k++) begin
            m_instr[k] = NOPI; m_valid[k] = 1'b0; m_cpc[k] = 32'd0; m_ipc[k] = 32'd0;
        end
        m_sc = 0; m_bc = 0; m_rc = 0; m_ack = 1'b0;
    endtask

    task automatic m_comb();
        for (int k = 0; k < STAGES; k++) begin
            m_stall[k] = 1'b0;
            for (int j = k; j < STAGES; j++) if (stalled[j]) m_stall[k] = 1'b1;
        end
        m_ack = flush_req && !m_stall[BR];
    endtask

    task automatic m_edge();
        logic [29:0] o_instr [1:STAGES-1];
        bit          o_valid [1:STAGES-1];
        logic [31:0] o_cpc   [1:STAGES-1];
        logic [31:0] o_ipc   [1:STAGES-1];
        bit          bub;
        o_instr = m_instr; o_valid = m_valid; o_cpc = m_cpc; o_ipc = m_ipc;
        bub = 1'b0;
        for (int k = 1; k < STAGES; k++) begin
            logic [29:0] si; bit sv; logic [31:0] sc, sn;
            if (k == 1) begin si = if_instr; sv = if_valid; sc = if_curr_pc; sn = if_inc_pc; end
            else begin si = o_instr[k-1]; sv = o_valid[k-1]; sc = o_cpc[k-1]; sn = o_ipc[k-1]; end
            if (m_ack && k <= BR) begin
                m_instr[k] = NOPI; m_valid[k] = 1'b0;
            end else if (m_stall[k]) begin
                m_instr[k] = o_instr[k];
            end else if (m_stall[k-1]) begin
                m_instr[k] = NOPI; m_valid[k] = 1'b0;
                if (sv) bub = 1'b1;
            end else begin
                m_instr[k] = si; m_valid[k] = sv; m_cpc[k] = sc; m_ipc[k] = sn;
            end
        end
        if (m_stall[0]) m_sc = sat(m_sc);
        if (bub || m_ack) m_bc = sat(m_bc);
        if (o_valid[STAGES-1] && !m_stall[STAGES-1]) m_rc = sat(m_rc);
    endtask

    task automatic check_regs();
        for (int k = 1; k < STAGES; k++) begin
            chk($sformatf("valid%0d", k), valid[k-1], m_valid[k]);
            chk($sformatf("instr%0d", k), instr[(k-1)*30 +: 30], m_instr[k]);
            if (m_valid[k]) begin
                chk($sformatf("curr_pc%0d", k), curr_pc[(k-1)*XLEN +: XLEN], m_cpc[k]);
                chk($sformatf("inc_pc%0d", k), inc_pc[(k-1)*XLEN +: XLEN], m_ipc[k]);
            end
        end
        chk("stall_cnt", stall_cnt, m_sc);
        chk("bubble_cnt", bubble_cnt, m_bc);
        chk("retire_cnt", retire_cnt, m_rc);
    endtask

    // Inputs are set before calling; checks stall/ack before the edge, registers after it.
    task automatic cyc();
        @(negedge clk);
        m_comb();
        chk("stall", stall, {m_stall[3], m_stall[2], m_stall[1], m_stall[0]});
        chk("flush_ack", flush_ack, m_ack);
        m_edge();
        @(posedge clk);
        #1;
        check_regs();
        if (m_ack) flush_req = 1'b0;
    endtask

    task automatic feed(input bit v);
        if_valid   = v;
        if_instr   = 30'($urandom());
        if_curr_pc = $urandom() & 32'hFFFF_FFFE;
        if_inc_pc  = if_curr_pc + 32'd4;
    endtask

    // Asynchronous reset applied and released between clock edges.
    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        m_reset();
        check_regs();
        for (int k = 1; k < STAGES; k++) chk("rst_pc", curr_pc[(k-1)*XLEN +: XLEN], 32'd0);
        flush_req = 1'b0;
        stalled   = 4'b0000;
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; flush_req = 1'b0; stalled = 4'b0000;
        feed(1'b0);
        @(posedge clk);
        #1;
        do_reset();

        // Stream of 8 valid instructions, then drain.
        for (int i = 0; i < 8; i++) begin feed(1'b1); cyc(); end
        for (int i = 0; i < 4; i++) begin feed(1'b0); cyc(); end
        chk("retire8", retire_cnt, 4'd8);

        // Fill, then stall the last stage for three cycles.
        for (int i = 0; i < 3; i++) begin feed(1'b1); cyc(); end
        stalled = 4'b1000;
        for (int i = 0; i < 3; i++) begin feed(1'b1); cyc(); end
        chk("stall_all", stall, 4'b1111);
        stalled = 4'b0000; feed(1'b1); cyc();

        // One-cycle stall at stage 1 with the pipe full injects a bubble.
        stalled = 4'b0010; feed(1'b1); cyc();
        stalled = 4'b0000; feed(1'b1); cyc();

        // Flush with no stall is acknowledged immediately.
        for (int i = 0; i < 2; i++) begin feed(1'b1); cyc(); end
        flush_req = 1'b1; feed(1'b1); cyc();
        chk("flush_v1", valid[0], 1'b0);
        feed(1'b1); cyc();

        // Flush held off by a downstream stall.
        flush_req = 1'b1; stalled = 4'b1000;
        for (int i = 0; i < 2; i++) begin feed(1'b1); cyc(); end
        chk("flush_held", flush_req, 1'b1);
        stalled = 4'b0000; feed(1'b1); cyc();
        feed(1'b1); cyc();

        // Random traffic with held flush requests.
        for (int i = 0; i < 400; i++) begin
            for (int b = 0; b < STAGES; b++) stalled[b] = ($urandom_range(0, 4) == 0);
            if (!flush_req) flush_req = ($urandom_range(0, 7) == 0);
            feed($urandom_range(0, 3) != 0);
            cyc();
        end

        // Counter saturation, then reset mid-flush and mid-stall.
        do_reset();
        stalled = 4'b0001;
        for (int i = 0; i < 20; i++) begin feed(1'b1); cyc(); end
        chk("stall_sat", stall_cnt, 4'hF);
        flush_req = 1'b1; stalled = 4'b1000; feed(1'b1);
        do_reset();
        chk("rst_valid", valid, 3'b000);
        for (int i = 0; i < 6; i++) begin feed(1'b1); cyc(); end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
